voq_pri_req: RTL

Per-input VOQ occupancy tracker and priority request generator for the pSLIP scheduler. Keeps one cell counter per (output, priority class). For each output it reports the highest occupied class as a C-bit code, and hands that snapshot to the downstream bit-serial priority selector using the selector's update/ready handshake. Sits directly upstream of the priority selector and consumes dequeue notifications from the grant path.

---
 rtl/voq_pri_req.sv | 138 +++++++++++++
 1 files changed

// File: rtl/voq_pri_req.sv
// rtl/voq_pri_req.sv - per-input VOQ occupancy counters and priority snapshot hand-off to the priority selector
module voq_pri_req #(
    parameter int N     = 16,
    parameter int P     = 4,
    parameter int C     = $clog2(P),
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int NW    = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enq_valid_i,
    input  logic [NW-1:0]   enq_dest_i,
    input  logic [C-1:0]    enq_pri_i,
    output logic            enq_ready_o,
    input  logic            deq_valid_i,
    input  logic [NW-1:0]   deq_dest_i,
    input  logic [C-1:0]    deq_pri_i,
    output logic            deq_err_o,
    input  logic            sel_ready_i,
    output logic            update_o,
    output logic [N*C-1:0]  pri_out_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Class 0 slots exist only to keep indexing simple; they are never hit.
    logic [CW-1:0] cnt_q [N][P];

    state_e         state_q, state_d;
    logic           dirty_q, dirty_d;
    logic           update_q, update_d;
    logic           deq_err_q, deq_err_d;
    logic [N*C-1:0] pri_out_q, pri_out_d;
    logic [N*C-1:0] pri_next;

    logic [CW-1:0]  enq_cnt, deq_cnt;
    logic           enq_fire, deq_ok, same_ctr, cnt_change;

    always_comb begin
        enq_cnt     = cnt_q[enq_dest_i][enq_pri_i];
        deq_cnt     = cnt_q[deq_dest_i][deq_pri_i];
        enq_ready_o = (enq_pri_i != '0) && (enq_cnt != CW'(DEPTH));
        enq_fire    = enq_valid_i && enq_ready_o;
        deq_ok      = deq_valid_i && (deq_pri_i != '0) && (deq_cnt != '0);
        same_ctr    = (enq_dest_i == deq_dest_i) && (enq_pri_i == deq_pri_i);
        // A simultaneous enqueue and dequeue on one counter leaves it untouched.
        cnt_change  = (enq_fire || deq_ok) && !(enq_fire && deq_ok && same_ctr);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < N; j++) begin
                for (int c = 0; c < P; c++) begin
                    cnt_q[j][c] <= '0;
                end
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                for (int c = 0; c < P; c++) begin
                    if (enq_fire && (enq_dest_i == NW'(j)) && (enq_pri_i == C'(c)) &&
                        !(deq_ok && same_ctr)) begin
                        cnt_q[j][c] <= cnt_q[j][c] + CW'(1);
                    end else if (deq_ok && (deq_dest_i == NW'(j)) && (deq_pri_i == C'(c)) &&
                                 !(enq_fire && same_ctr)) begin
                        cnt_q[j][c] <= cnt_q[j][c] - CW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        pri_next = '0;
        for (int j = 0; j < N; j++) begin
            for (int c = 1; c < P; c++) begin
                if (cnt_q[j][c] != '0) begin
                    pri_next[j*C +: C] = C'(c);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        dirty_d   = dirty_q;
        pri_out_d = pri_out_q;
        case (state_q)
            IDLE: begin
                if (dirty_q) begin
                    state_d   = ISSUE;
                    dirty_d   = 1'b0;
                    pri_out_d = pri_next;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (sel_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A change in the snapshot cycle itself must still be published later.
        if (cnt_change) begin
            dirty_d = 1'b1;
        end
        update_d  = (state_d == ISSUE);
        deq_err_d = deq_valid_i && !deq_ok;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            dirty_q   <= 1'b0;
            update_q  <= 1'b0;
            deq_err_q <= 1'b0;
            pri_out_q <= '0;
        end else begin
            state_q   <= state_d;
            dirty_q   <= dirty_d;
            update_q  <= update_d;
            deq_err_q <= deq_err_d;
            pri_out_q <= pri_out_d;
        end
    end

    assign update_o  = update_q;
    assign deq_err_o = deq_err_q;
    assign pri_out_o = pri_out_q;
    assign busy_o    = (state_q != IDLE);

endmodule
